cpu_dbg_ctrl: RTL and testbench
===============================

// Module: cpu_dbg_ctrl
// PURPOSE
//  Debug-side responder for the CPU debug interface (brk, ready, dbgreg_sel/dbgreg_out).
//  - Stalls the CPU on a brk pulse or a host halt command.
//  - Snapshots PCL, PCH, AC, X, Y and P through the register-select port.
//  - Streams the snapshot to the host over a valid/ready byte channel.
//  - Holds the CPU halted until the host sends continue.
//  Sits between the CPU core and the host UART tx/rx byte channels.
// PARAMETERS
//  HDR_BYTE    8'hB0  first byte of every snapshot packet
//  CMD_CONT    8'h01  host command: release CPU
//  CMD_RESEND  8'h02  host command: resend last snapshot (no re-capture)
//  CMD_HALT    8'h03  host command: halt CPU and capture
// PORTS
//  clk              in   1  system clock
//  rst              in   1  synchronous active-high reset
//  cpu_brk          in   1  one-cycle break pulse from CPU
//  cpu_dbgreg_out   in   8  CPU debug register read data (combinational from cpu_dbgreg_sel)
//  cpu_dbgreg_sel   out  4  CPU debug register select (0 PCL, 1 PCH, 2 AC, 3 X, 4 Y, 5 P)
//  cpu_ready        out  1  CPU ready; 0 = CPU stalled
//  tx_data          out  8  byte to host
//  tx_valid         out  1  tx_data valid
//  tx_ready         in   1  host accepts tx_data this cycle
//  rx_data          in   8  command byte from host
//  rx_valid         in   1  rx_data valid, single-cycle pulse, no backpressure
//  halted           out  1  1 while in HALTED state
// BEHAVIOUR
//  - Reset values: cpu_ready=1, cpu_dbgreg_sel=0, tx_valid=0, tx_data=0, halted=0.
//    Reset also sets state=RUN, idx=0 and clears snap[0..5] to 0.
//  - All outputs are registered.
//  - States: RUN, CAPTURE, SEND, HALTED.
//  - RUN:
//    - cpu_ready=1.
//    - cpu_brk=1, or rx_valid with rx_data==CMD_HALT, moves to CAPTURE next cycle.
//      On that transition cpu_ready=0, sel=0, idx=0.
//    - If both events occur in the same cycle, there is one capture only.
//    - Other rx bytes are ignored.
//  - CAPTURE:
//    - cpu_ready=0. The CPU is frozen because it gates internally on ready.
//    - Each cycle: snap[idx] <= cpu_dbgreg_out; idx++; sel <= idx+1.
//    - After idx==5 is stored: go to SEND, set byte counter=0, present HDR_BYTE.
//  - SEND:
//    - cpu_ready=0.
//    - Packet is 7 bytes: HDR_BYTE, snap[0..5] (PCL, PCH, AC, X, Y, P).
//    - tx_valid=1, and tx_data stays stable until the cycle tx_valid && tx_ready.
//      In that cycle the next byte is loaded, or tx_valid=0 after byte 6.
//    - After byte 6 is accepted: go to HALTED. tx_valid stays low.
//    - rx bytes received during SEND are dropped.
//  - HALTED:
//    - cpu_ready=0, halted=1.
//    - CMD_CONT: go to RUN; cpu_ready=1 and halted=0 next cycle.
//    - CMD_RESEND: go to SEND using the existing snap contents.
//    - CMD_HALT and other bytes: ignored.
//    - cpu_brk: ignored (the CPU is stalled).
//  - Latency: brk accepted in cycle n gives cpu_ready=0 from n+1.
//    Captures occur in n+1..n+6. First tx_valid (HDR_BYTE) occurs at n+7.
//  - Byte counter: 3 bits, range 0..6, never wraps. idx: 3 bits, range 0..5.
//  - Reset mid-operation: the next cycle shows reset values; any partial packet is abandoned.
//  - cpu_brk in any state other than RUN is ignored. No event is queued.
// TESTING
//  - Reset: assert rst 2 cycles -> cpu_ready=1, tx_valid=0, halted=0, sel=0.
//  - brk capture: model regs {12,80,55,AA,0F,82}, pulse brk at n, tx_ready=1
//    -> cpu_ready=0 at n+1; bytes B0,12,80,55,AA,0F,82 on n+7..n+13; halted=1 at n+14.
//  - Backpressure: tx_ready low 5 cycles on byte 2 -> tx_data holds 80 and tx_valid stays 1;
//    the stream resumes in order with no loss or duplication.
//  - Resend/continue: in HALTED send 02 -> same 7 bytes resent with no new sel sweep.
//    Then send 01 -> cpu_ready=1, halted=0 next cycle.
//  - Host halt and simultaneity: rx 03 with brk in the same RUN cycle -> exactly one packet.
//    rx 01 during SEND -> dropped, CPU remains stalled.
//  - Reset mid-SEND: rst after byte 3 -> tx_valid=0, cpu_ready=1 next cycle.
//    A later brk produces a full fresh packet.

Source files
------------

// File: rtl/cpu_dbg_ctrl.sv
// Debug responder: stalls the CPU on brk or host halt, snapshots PCL/PCH/AC/X/Y/P,
// streams a 7-byte packet to the host and holds the CPU until a continue command.
module cpu_dbg_ctrl #(
  parameter logic [7:0] HDR_BYTE   = 8'hB0,
  parameter logic [7:0] CMD_CONT   = 8'h01,
  parameter logic [7:0] CMD_RESEND = 8'h02,
  parameter logic [7:0] CMD_HALT   = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_brk,
  input  logic [7:0] cpu_dbgreg_out,
  output logic [3:0] cpu_dbgreg_sel,
  output logic       cpu_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       halted
);

  typedef enum logic [1:0] {RUN, CAPTURE, SEND, HALTED} state_t;

  state_t     state, state_d;
  logic [2:0] idx, idx_d;
  logic [2:0] bcnt, bcnt_d;
  logic [7:0] snap [6];
  logic       snap_we;
  logic       cpu_ready_d, tx_valid_d, halted_d;
  logic [3:0] sel_d;
  logic [7:0] tx_data_d;
  logic       rx_cont, rx_resend, rx_halt;

  assign rx_cont   = rx_valid && (rx_data == CMD_CONT);
  assign rx_resend = rx_valid && (rx_data == CMD_RESEND);
  assign rx_halt   = rx_valid && (rx_data == CMD_HALT);

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    bcnt_d      = bcnt;
    sel_d       = cpu_dbgreg_sel;
    cpu_ready_d = cpu_ready;
    tx_valid_d  = tx_valid;
    tx_data_d   = tx_data;
    snap_we     = 1'b0;
    unique case (state)
      RUN: begin
        cpu_ready_d = 1'b1;
        if (cpu_brk || rx_halt) begin
          state_d     = CAPTURE;
          cpu_ready_d = 1'b0;
          sel_d       = 4'd0;
          idx_d       = 3'd0;
        end
      end
      CAPTURE: begin
        cpu_ready_d = 1'b0;
        snap_we     = 1'b1;
        if (idx == 3'd5) begin
          // last register stored; header goes out on the following cycle
          state_d    = SEND;
          idx_d      = 3'd0;
          sel_d      = 4'd0;
          bcnt_d     = 3'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
        end else begin
          idx_d = idx + 3'd1;
          sel_d = {1'b0, idx + 3'd1};
        end
      end
      SEND: begin
        cpu_ready_d = 1'b0;
        tx_valid_d  = 1'b1;
        if (tx_ready) begin
          if (bcnt == 3'd6) begin
            state_d    = HALTED;
            tx_valid_d = 1'b0;
          end else begin
            // byte bcnt+1 of the packet is snap[bcnt]
            bcnt_d    = bcnt + 3'd1;
            tx_data_d = snap[bcnt];
          end
        end
      end
      HALTED: begin
        cpu_ready_d = 1'b0;
        if (rx_cont) begin
          state_d     = RUN;
          cpu_ready_d = 1'b1;
        end else if (rx_resend) begin
          state_d    = SEND;
          bcnt_d     = 3'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
        end
      end
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      idx            <= 3'd0;
      bcnt           <= 3'd0;
      cpu_dbgreg_sel <= 4'd0;
      cpu_ready      <= 1'b1;
      tx_valid       <= 1'b0;
      tx_data        <= 8'h00;
      halted         <= 1'b0;
      for (int i = 0; i < 6; i++) snap[i] <= 8'h00;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      bcnt           <= bcnt_d;
      cpu_dbgreg_sel <= sel_d;
      cpu_ready      <= cpu_ready_d;
      tx_valid       <= tx_valid_d;
      tx_data        <= tx_data_d;
      halted         <= halted_d;
      if (snap_we) snap[idx] <= cpu_dbgreg_out;
    end
  end

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Scoreboard bench for cpu_dbg_ctrl: stimulus pushes expected packet bytes,
// a negedge monitor pops and compares on every tx handshake.
module tb_cpu_dbg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_brk;
  logic [7:0] cpu_dbgreg_out;
  logic [3:0] cpu_dbgreg_sel;
  logic       cpu_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       halted;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] regs [6];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  cpu_dbg_ctrl dut (
    .clk(clk), .rst(rst), .cpu_brk(cpu_brk),
    .cpu_dbgreg_out(cpu_dbgreg_out), .cpu_dbgreg_sel(cpu_dbgreg_sel),
    .cpu_ready(cpu_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .halted(halted)
  );

  // combinational CPU register file model
  assign cpu_dbgreg_out = (cpu_dbgreg_sel < 4'd6) ? regs[cpu_dbgreg_sel[2:0]] : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL tx_extra: got %0h expected no byte", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_b});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [47:0] v);
    for (int i = 0; i < 6; i++) regs[i] = v[47-8*i -: 8];
  endtask

  task automatic push_pkt(input logic [47:0] v, input int n);
    exp_q.push_back(8'hB0);
    for (int i = 0; i < n - 1; i++) exp_q.push_back(v[47-8*i -: 8]);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_brk();
    cpu_brk = 1'b1;
    tick();
    cpu_brk = 1'b0;
  endtask

  task automatic wait_halted(input string nm);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (halted) begin ok = 1; break; end
      tick();
    end
    chk(nm, {31'h0, ok}, 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_valid) begin ok = 1; break; end
      tick();
    end
    chk(nm, {31'h0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; cpu_brk = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    set_regs(48'h0);
    tick(); tick();
    chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'd1);
    chk("rst_tx_valid",  {31'h0, tx_valid}, 32'd0);
    chk("rst_halted",    {31'h0, halted}, 32'd0);
    chk("rst_sel",       {28'h0, cpu_dbgreg_sel}, 32'd0);
    chk("rst_tx_data",   {24'h0, tx_data}, 32'd0);
    rst = 1'b0;
    tick();

    // brk capture with exact latency
    tx_ready = 1'b1;
    set_regs(48'h12_80_55_AA_0F_82);
    push_pkt(48'h12_80_55_AA_0F_82, 7);
    pulse_brk();
    chk("brk_ready_n1", {31'h0, cpu_ready}, 32'd0);
    repeat (5) tick();
    chk("no_valid_n6", {31'h0, tx_valid}, 32'd0);
    tick();
    for (int k = 0; k < 7; k++) begin
      chk("stream_valid", {31'h0, tx_valid}, 32'd1);
      chk("stream_stall", {31'h0, cpu_ready}, 32'd0);
      tick();
    end
    chk("halted_n14", {31'h0, halted}, 32'd1);
    chk("idle_n14",   {31'h0, tx_valid}, 32'd0);

    // host commands ignored in HALTED
    send_rx(8'h03);
    pulse_brk();
    chk("halt_ign_halted", {31'h0, halted}, 32'd1);
    chk("halt_ign_valid",  {31'h0, tx_valid}, 32'd0);

    // resend with changed CPU regs: old snapshot must come out
    set_regs(48'hDE_AD_BE_EF_01_02);
    push_pkt(48'h12_80_55_AA_0F_82, 7);
    send_rx(8'h02);
    chk("resend_valid",  {31'h0, tx_valid}, 32'd1);
    chk("resend_hdr",    {24'h0, tx_data}, 32'hB0);
    chk("resend_halted", {31'h0, halted}, 32'd0);
    wait_halted("resend_done");
    send_rx(8'h01);
    chk("cont_ready",  {31'h0, cpu_ready}, 32'd1);
    chk("cont_halted", {31'h0, halted}, 32'd0);

    // backpressure on byte 2
    set_regs(48'h12_80_55_AA_0F_82);
    push_pkt(48'h12_80_55_AA_0F_82, 7);
    pulse_brk();
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_valid && tx_data == 8'h80) begin found = 1; break; end
      tick();
    end
    chk("bp_reach_byte2", {31'h0, found}, 32'd1);
    tx_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_hold_data",  {24'h0, tx_data}, 32'h80);
      chk("bp_hold_valid", {31'h0, tx_valid}, 32'd1);
    end
    tx_ready = 1'b1;
    wait_halted("bp_done");
    send_rx(8'h01);

    // simultaneous brk + host halt, then rx continue during SEND
    set_regs(48'h11_22_33_44_55_66);
    push_pkt(48'h11_22_33_44_55_66, 7);
    rx_data = 8'h03; rx_valid = 1'b1; cpu_brk = 1'b1;
    tick();
    rx_valid = 1'b0; cpu_brk = 1'b0;
    chk("simul_ready", {31'h0, cpu_ready}, 32'd0);
    wait_valid("simul_valid");
    send_rx(8'h01);
    chk("send_drop_ready", {31'h0, cpu_ready}, 32'd0);
    wait_halted("simul_done");
    repeat (10) tick();
    chk("single_pkt_valid",  {31'h0, tx_valid}, 32'd0);
    chk("single_pkt_halted", {31'h0, halted}, 32'd1);
    chk("single_pkt_q", exp_q.size(), 32'd0);
    send_rx(8'h01);

    // reset after byte 3 of a packet
    set_regs(48'hA1_A2_A3_A4_A5_A6);
    push_pkt(48'hA1_A2_A3_A4_A5_A6, 4);
    pulse_brk();
    wait_valid("mid_valid");
    repeat (4) tick();
    rst = 1'b1; tx_ready = 1'b0;
    tick();
    chk("mid_rst_valid",  {31'h0, tx_valid}, 32'd0);
    chk("mid_rst_ready",  {31'h0, cpu_ready}, 32'd1);
    chk("mid_rst_halted", {31'h0, halted}, 32'd0);
    chk("mid_rst_q", exp_q.size(), 32'd0);
    rst = 1'b0; tx_ready = 1'b1;
    tick();
    set_regs(48'hC1_C2_C3_C4_C5_C6);
    push_pkt(48'hC1_C2_C3_C4_C5_C6, 7);
    pulse_brk();
    wait_halted("fresh_done");
    chk("fresh_q", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
